// File: rtl/uart_rx.sv
// 8N1 UART receiver with a free-running 16x oversample tick generator.
// Delivers each correctly framed byte as an rx_done pulse plus rx_data.
module uart_rx #(
    parameter int NB_DATA       = 8,
    parameter int NB_STOP_TICKS = 16,
    parameter int TICK_DIV      = 163,
    parameter int NB_TICK_CNT   = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_done,
    output logic               o_frame_error,
    output logic               o_busy
);
    localparam int NB_BIT_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    localparam logic [NB_TICK_CNT-1:0] TICK_LAST = NB_TICK_CNT'(TICK_DIV - 1);
    localparam logic [NB_TICK_CNT-1:0] TICK_ONE  = NB_TICK_CNT'(1);
    localparam logic [4:0]             S_MID     = 5'd7;
    localparam logic [4:0]             S_BIT     = 5'd15;
    localparam logic [4:0]             S_STOP    = 5'(NB_STOP_TICKS - 1);
    localparam logic [NB_BIT_CNT-1:0]  N_LAST    = NB_BIT_CNT'(NB_DATA - 1);
    localparam logic [NB_BIT_CNT-1:0]  N_ONE     = NB_BIT_CNT'(1);

    logic                   rx_meta_q, rx_s_q;
    logic [NB_TICK_CNT-1:0] tick_cnt_q;
    logic                   tick;
    logic [2:0]             state_q, state_d;
    logic [4:0]             s_q, s_d;
    logic [NB_BIT_CNT-1:0]  n_q, n_d;
    logic [NB_DATA-1:0]     shreg_q, shreg_d;
    logic [NB_DATA-1:0]     data_q, data_d;
    logic                   done_q, done_d;
    logic                   ferr_q, ferr_d;

    // Tick phase is deliberately not realigned to the start edge.
    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_BIT) begin
                        shreg_d = {rx_s_q, shreg_q[NB_DATA-1:1]};
                        s_d     = '0;
                        if (n_q == N_LAST) state_d = STOP;
                        else               n_d     = n_q + N_ONE;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_STOP) begin
                        if (rx_s_q) begin
                            data_d  = shreg_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            // Held-low line must rise before another start is accepted.
            BREAK: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            tick_cnt_q <= '0;
            state_q    <= IDLE;
            s_q        <= '0;
            n_q        <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= i_rx;
            rx_s_q     <= rx_meta_q;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TICK_ONE;
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    assign o_rx_data     = data_q;
    assign o_rx_done     = done_q;
    assign o_frame_error = ferr_q;
    assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with TICK_DIV=4 (64 clocks per bit).
module tb_uart_rx;
    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_rx;
    logic [7:0] o_rx_data;
    logic       o_rx_done;
    logic       o_frame_error;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Event monitor state
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         wide_cnt = 0;
    int         busy_bad = 0;
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] done_log [0:15];

    uart_rx #(
        .NB_DATA(8), .NB_STOP_TICKS(16), .TICK_DIV(4), .NB_TICK_CNT(2)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_rx(i_rx),
        .o_rx_data(o_rx_data),
        .o_rx_done(o_rx_done),
        .o_frame_error(o_frame_error),
        .o_busy(o_busy)
    );

    always #5 i_clock = ~i_clock;

    always @(negedge i_clock) begin
        prev_done <= o_rx_done;
        prev_ferr <= o_frame_error;
        if (o_rx_done === 1'b1) begin
            done_log[done_cnt[3:0]] <= o_rx_data;
            done_cnt <= done_cnt + 1;
        end
        if (o_frame_error === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (o_rx_done === 1'b1 && o_frame_error === 1'b1) both_cnt <= both_cnt + 1;
        if ((prev_done && o_rx_done === 1'b1) || (prev_ferr && o_frame_error === 1'b1))
            wide_cnt <= wide_cnt + 1;
        if (prev_done && o_busy === 1'b1) busy_bad <= busy_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int cycles);
        i_rx = v;
        repeat (cycles) @(posedge i_clock);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic stop_lvl, input int stop_cycles);
        for (int i = 0; i < 8; i++) hold(b[i], 64);
        hold(stop_lvl, stop_cycles);
    endtask

    task automatic send_frame(input logic [7:0] b);
        hold(1'b0, 64);
        send_bits(b, 1'b1, 64);
    endtask

    initial begin
        logic [7:0] b77;
        b77 = 8'h77;
        i_reset = 1'b1;
        i_rx    = 1'b1;
        repeat (3) @(posedge i_clock);
        #1;
        chk("rst_data", o_rx_data, 0);
        chk("rst_done", o_rx_done, 0);
        chk("rst_ferr", o_frame_error, 0);
        chk("rst_busy", o_busy, 0);
        i_reset = 1'b0;
        hold(1'b1, 20);

        // 0xA5 normal frame
        hold(1'b0, 64);
        chk("a5_busy_mid", o_busy, 1);
        send_bits(8'hA5, 1'b1, 64);
        hold(1'b1, 16);
        chk("a5_done_cnt", done_cnt, 1);
        chk("a5_log", done_log[0], 8'hA5);
        chk("a5_data", o_rx_data, 8'hA5);
        chk("a5_ferr_cnt", ferr_cnt, 0);
        chk("a5_busy_idle", o_busy, 0);

        // Start-bit glitch
        hold(1'b0, 20);
        chk("glitch_busy", o_busy, 1);
        hold(1'b1, 100);
        chk("glitch_idle", o_busy, 0);
        chk("glitch_done_cnt", done_cnt, 1);
        chk("glitch_ferr_cnt", ferr_cnt, 0);
        chk("glitch_data", o_rx_data, 8'hA5);

        // 0x3C with stop held low -> frame error, break, then 0x11
        hold(1'b0, 64);
        send_bits(8'h3C, 1'b0, 200);
        chk("brk_ferr_cnt", ferr_cnt, 1);
        chk("brk_done_cnt", done_cnt, 1);
        chk("brk_data", o_rx_data, 8'hA5);
        chk("brk_busy", o_busy, 1);
        hold(1'b1, 64);
        chk("brk_exit", o_busy, 0);
        send_frame(8'h11);
        hold(1'b1, 16);
        chk("f11_done_cnt", done_cnt, 2);
        chk("f11_log", done_log[1], 8'h11);
        chk("f11_data", o_rx_data, 8'h11);
        chk("f11_ferr_cnt", ferr_cnt, 1);

        // Back-to-back 0x00, 0xFF
        send_frame(8'h00);
        send_frame(8'hFF);
        hold(1'b1, 16);
        chk("b2b_done_cnt", done_cnt, 4);
        chk("b2b_log0", done_log[2], 8'h00);
        chk("b2b_log1", done_log[3], 8'hFF);
        chk("b2b_data", o_rx_data, 8'hFF);

        // Reset during data bit 3 of 0x77
        hold(1'b0, 64);
        for (int i = 0; i < 3; i++) hold(b77[i], 64);
        hold(b77[3], 32);
        i_reset = 1'b1;
        i_rx    = 1'b1;
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        chk("mrst_data", o_rx_data, 0);
        chk("mrst_done", o_rx_done, 0);
        chk("mrst_ferr", o_frame_error, 0);
        chk("mrst_busy", o_busy, 0);
        hold(1'b1, 400);
        chk("mrst_done_cnt", done_cnt, 4);
        chk("mrst_ferr_cnt", ferr_cnt, 1);
        send_frame(8'h5A);
        hold(1'b1, 16);
        chk("f5a_done_cnt", done_cnt, 5);
        chk("f5a_log", done_log[4], 8'h5A);
        chk("f5a_data", o_rx_data, 8'h5A);

        chk("never_both", both_cnt, 0);
        chk("single_cycle", wide_cnt, 0);
        chk("busy_after_done", busy_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
